// File: rtl/move_batch_streamer_if.sv
// Request/stream/config bundle for move_batch_streamer.
// MOVE_BATCH_STREAMER_REVERSE_EN adds the reverse request bit.
interface move_batch_streamer_if #(
    parameter int MOVE_W = 4,
    parameter int IDX_W  = 6,
    parameter int SLOT_W = 5,
    parameter int LEN_W  = 5
);
    logic              cfg_we;
    logic              cfg_len_we;
    logic [IDX_W-1:0]  cfg_batch;
    logic [SLOT_W-1:0] cfg_slot;
    logic [MOVE_W-1:0] cfg_move;
    logic [LEN_W-1:0]  cfg_len;
    logic              start;
    logic [IDX_W-1:0]  batch_idx;
`ifdef MOVE_BATCH_STREAMER_REVERSE_EN
    logic              reverse;
`endif
    logic              busy;
    logic              move_valid;
    logic [MOVE_W-1:0] move;
    logic              move_ready;
    logic              done;
    logic              err;

    // master: requester/config side; slave: the streamer
    modport master (
        output cfg_we, cfg_len_we, cfg_batch, cfg_slot, cfg_move, cfg_len,
        output start, batch_idx, move_ready,
`ifdef MOVE_BATCH_STREAMER_REVERSE_EN
        output reverse,
`endif
        input  busy, move_valid, move, done, err
    );
    modport slave (
        input  cfg_we, cfg_len_we, cfg_batch, cfg_slot, cfg_move, cfg_len,
        input  start, batch_idx, move_ready,
`ifdef MOVE_BATCH_STREAMER_REVERSE_EN
        input  reverse,
`endif
        output busy, move_valid, move, done, err
    );
endinterface

// File: rtl/move_batch_streamer.sv
// Streams a programmable batch of move codes one per valid/ready handshake, then pulses done.
// Define MOVE_BATCH_STREAMER_REVERSE_EN to allow inverse, back-to-front streaming.
module move_batch_streamer #(
    parameter int MOVE_W      = 4,
    parameter int NUM_BATCHES = 53,
    parameter int MAX_LEN     = 20,
    parameter int IDX_W       = 6,
    parameter int SLOT_W      = 5,
    parameter int LEN_W       = 5
) (
    input logic                  clock,
    input logic                  reset,
    move_batch_streamer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FETCH, EMIT, FINISH} state_t;

    localparam logic [IDX_W:0]   NB_X  = (IDX_W+1)'(NUM_BATCHES);
    localparam logic [SLOT_W:0]  ML_X  = (SLOT_W+1)'(MAX_LEN);
    localparam logic [LEN_W-1:0] ML_L  = LEN_W'(MAX_LEN);

    state_t            state;
    logic [MOVE_W-1:0] mtab    [NUM_BATCHES][MAX_LEN];
    logic [LEN_W-1:0]  len_tab [NUM_BATCHES];
    logic [IDX_W-1:0]  idx_q;
    logic [SLOT_W-1:0] slot_q;
    logic [LEN_W-1:0]  rem_q;   // moves left after the one presented
    logic              rev_q;
    logic              rev_in;

`ifdef MOVE_BATCH_STREAMER_REVERSE_EN
    assign rev_in = bus.reverse;
`else
    assign rev_in = 1'b0;
`endif

    function automatic logic [MOVE_W-1:0] xform(input logic [MOVE_W-1:0] c, input logic r);
        return (r && c >= MOVE_W'(2)) ? (c ^ MOVE_W'(1)) : c;
    endfunction

    // Config is frozen while a batch is in flight so the active batch cannot change.
    logic cfg_open, cfg_ok;
    assign cfg_open = (state == IDLE) || (state == FINISH);
    assign cfg_ok   = cfg_open && ({1'b0, bus.cfg_batch} < NB_X);

    logic              req_ok;
    logic [LEN_W-1:0]  req_len;
    assign req_ok  = {1'b0, bus.batch_idx} < NB_X;
    assign req_len = req_ok ? len_tab[bus.batch_idx] : '0;

    logic [SLOT_W-1:0] slot_nx;
    logic [MOVE_W-1:0] cur_code, nxt_code;
    assign slot_nx  = rev_q ? slot_q - 1'b1 : slot_q + 1'b1;
    assign cur_code = xform(mtab[idx_q][slot_q], rev_q);
    assign nxt_code = xform(mtab[idx_q][slot_nx], rev_q);

    always_ff @(posedge clock) begin
        if (cfg_ok && bus.cfg_we && ({1'b0, bus.cfg_slot} < ML_X))
            mtab[bus.cfg_batch][bus.cfg_slot] <= bus.cfg_move;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_BATCHES; i++) len_tab[i] <= '0;
        end else if (cfg_ok && bus.cfg_len_we) begin
            len_tab[bus.cfg_batch] <= (bus.cfg_len > ML_L) ? ML_L : bus.cfg_len;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            bus.busy       <= 1'b0;
            bus.move_valid <= 1'b0;
            bus.move       <= '0;
            bus.done       <= 1'b0;
            bus.err        <= 1'b0;
            idx_q          <= '0;
            slot_q         <= '0;
            rem_q          <= '0;
            rev_q          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (req_len != '0) begin
                            idx_q    <= bus.batch_idx;
                            rev_q    <= rev_in;
                            slot_q   <= rev_in ? SLOT_W'(req_len - 1'b1) : '0;
                            rem_q    <= req_len - 1'b1;
                            bus.busy <= 1'b1;
                            state    <= FETCH;
                        end else begin
                            bus.done <= 1'b1;
                            bus.err  <= 1'b1;
                            state    <= FINISH;
                        end
                    end
                end
                FETCH: begin
                    bus.move       <= cur_code;
                    bus.move_valid <= 1'b1;
                    state          <= EMIT;
                end
                EMIT: begin
                    if (bus.move_ready) begin
                        if (rem_q == '0) begin
                            bus.move_valid <= 1'b0;
                            bus.move       <= '0;
                            bus.busy       <= 1'b0;
                            bus.done       <= 1'b1;
                            state          <= FINISH;
                        end else begin
                            slot_q   <= slot_nx;
                            rem_q    <= rem_q - 1'b1;
                            bus.move <= nxt_code;
                        end
                    end
                end
                default: begin
                    bus.done <= 1'b0;
                    bus.err  <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_move_batch_streamer.sv
// Directed self-checking bench for move_batch_streamer.
module tb_move_batch_streamer;
    logic clock = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clock = ~clock;

    move_batch_streamer_if #(.MOVE_W(4), .IDX_W(6), .SLOT_W(5), .LEN_W(5)) bus ();

    move_batch_streamer #(
        .MOVE_W(4), .NUM_BATCHES(53), .MAX_LEN(20), .IDX_W(6), .SLOT_W(5), .LEN_W(5)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    logic [3:0] exp2 [6] = '{4'd2, 4'd2, 4'd9, 4'd9, 4'd9, 4'd13};
    logic       rdy2 [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic cfg_w(input int b, input int s, input int m, input bit lw, input int l);
        bus.cfg_we     = 1'b1;
        bus.cfg_len_we = lw;
        bus.cfg_batch  = 6'(b);
        bus.cfg_slot   = 5'(s);
        bus.cfg_move   = 4'(m);
        bus.cfg_len    = 5'(l);
        step();
        bus.cfg_we     = 1'b0;
        bus.cfg_len_we = 1'b0;
    endtask

    task automatic kick(input int idx);
        bus.start     = 1'b1;
        bus.batch_idx = 6'(idx);
        step();
        bus.start     = 1'b0;
    endtask

    initial begin
        int         cnt;
        bit         got_done;
        logic [3:0] last;
        reset          = 1'b1;
        bus.cfg_we     = 1'b0;
        bus.cfg_len_we = 1'b0;
        bus.cfg_batch  = '0;
        bus.cfg_slot   = '0;
        bus.cfg_move   = '0;
        bus.cfg_len    = '0;
        bus.start      = 1'b0;
        bus.batch_idx  = '0;
        bus.move_ready = 1'b0;
`ifdef MOVE_BATCH_STREAMER_REVERSE_EN
        bus.reverse    = 1'b0;
`endif
        step(); step();
        chk("rst_busy",  32'(bus.busy), 0);
        chk("rst_valid", 32'(bus.move_valid), 0);
        chk("rst_move",  32'(bus.move), 0);
        chk("rst_done",  32'(bus.done), 0);
        chk("rst_err",   32'(bus.err), 0);
        reset = 1'b0;
        step();

        // batch 1 = {R, Li, Di}; length written together with slot 0
        cfg_w(1, 0, 2, 1'b1, 3);
        cfg_w(1, 1, 9, 1'b0, 0);
        cfg_w(1, 2, 13, 1'b0, 0);
        // batch 2: 20 moves, length 25 saturates to 20
        for (int i = 0; i < 20; i++) cfg_w(2, i, 2 + (i % 12), (i == 0), 25);

        // forward stream, ready held high
        bus.move_ready = 1'b1;
        kick(1);
        chk("fwd_busy_t1",  32'(bus.busy), 1);
        chk("fwd_valid_t1", 32'(bus.move_valid), 0);
        step();
        chk("fwd_valid_t2", 32'(bus.move_valid), 1);
        chk("fwd_move_t2",  32'(bus.move), 2);
        step();
        chk("fwd_move_t3",  32'(bus.move), 9);
        step();
        chk("fwd_move_t4",  32'(bus.move), 13);
        chk("fwd_busy_t4",  32'(bus.busy), 1);
        step();
        chk("fwd_done_t5",  32'(bus.done), 1);
        chk("fwd_err_t5",   32'(bus.err), 0);
        chk("fwd_valid_t5", 32'(bus.move_valid), 0);
        chk("fwd_move_t5",  32'(bus.move), 0);
        step();
        chk("fwd_done_t6",  32'(bus.done), 0);

        // backpressure: codes held until their handshake
        bus.move_ready = 1'b0;
        kick(1);
        step();
        for (int k = 0; k < 6; k++) begin
            chk("bp_valid", 32'(bus.move_valid), 1);
            chk("bp_move",  32'(bus.move), 32'(exp2[k]));
            bus.move_ready = rdy2[k];
            step();
        end
        chk("bp_done", 32'(bus.done), 1);
        step();

        // invalid requests: empty batch and out-of-range index
        kick(5);
        chk("len0_done",  32'(bus.done), 1);
        chk("len0_err",   32'(bus.err), 1);
        chk("len0_valid", 32'(bus.move_valid), 0);
        step();
        chk("len0_done_clr", 32'(bus.done), 0);
        kick(60);
        chk("oor_done",  32'(bus.done), 1);
        chk("oor_err",   32'(bus.err), 1);
        chk("oor_valid", 32'(bus.move_valid), 0);
        step();
        chk("oor_err_clr", 32'(bus.err), 0);

        // start and cfg write while busy are both ignored
        bus.move_ready = 1'b0;
        kick(1);
        step();
        chk("ign_move_t2", 32'(bus.move), 2);
        bus.start      = 1'b1;
        bus.batch_idx  = 6'd2;
        bus.cfg_we     = 1'b1;
        bus.cfg_batch  = 6'd1;
        bus.cfg_slot   = 5'd0;
        bus.cfg_move   = 4'd4;
        step();
        bus.start      = 1'b0;
        bus.cfg_we     = 1'b0;
        chk("ign_hold", 32'(bus.move), 2);
        bus.move_ready = 1'b1;
        step();
        chk("ign_move2", 32'(bus.move), 9);
        step();
        chk("ign_move3", 32'(bus.move), 13);
        step();
        chk("ign_done", 32'(bus.done), 1);
        step(); step();
        chk("ign_noqueue", 32'(bus.busy), 0);
        kick(1);
        step();
        chk("rerun_first", 32'(bus.move), 2);
        step(); step(); step();
        chk("rerun_done", 32'(bus.done), 1);
        step();

        // saturated length: exactly 20 moves, last code 2+(19%12)=9
        cnt = 0; got_done = 1'b0; last = '0;
        kick(2);
        for (int c = 0; c < 40 && !got_done; c++) begin
            step();
            if (bus.move_valid) begin cnt++; last = bus.move; end
            if (bus.done) got_done = 1'b1;
        end
        chk("sat_done_seen", 32'(got_done), 1);
        chk("sat_count", 32'(cnt), 20);
        chk("sat_last", 32'(last), 9);
        step();

`ifdef MOVE_BATCH_STREAMER_REVERSE_EN
        bus.reverse = 1'b1;
        kick(1);
        bus.reverse = 1'b0;
        step();
        chk("rev_move0", 32'(bus.move), 12);
        step();
        chk("rev_move1", 32'(bus.move), 8);
        step();
        chk("rev_move2", 32'(bus.move), 3);
        step();
        chk("rev_done", 32'(bus.done), 1);
        step();
`endif

        // reset mid-stream on the second move
        kick(1);
        step(); step();
        chk("mid_move2", 32'(bus.move), 9);
        reset = 1'b1;
        #1;
        chk("mid_busy",  32'(bus.busy), 0);
        chk("mid_valid", 32'(bus.move_valid), 0);
        chk("mid_move",  32'(bus.move), 0);
        chk("mid_done",  32'(bus.done), 0);
        @(posedge clock);
        #1 reset = 1'b0;
        step();
        chk("mid_nodone", 32'(bus.done), 0);
        kick(1);
        chk("post_rst_done", 32'(bus.done), 1);
        chk("post_rst_err",  32'(bus.err), 1);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
